// File: rtl/prisoners_if.sv
// Box store bus: the engine requests a box by index and the store answers
// with the box content and a one-cycle acknowledge strobe.
interface prisoners_if;
  logic       box_req;
  logic [7:0] box_addr;
  logic [7:0] input_data;
  logic       box_ack;

  modport master (
    output box_req,
    output box_addr,
    input  input_data,
    input  box_ack
  );

  modport slave (
    input  box_req,
    input  box_addr,
    output input_data,
    output box_ack
  );
endinterface

// File: rtl/prisoners.sv
// Cycle-following engine for the prisoners puzzle. Each prisoner starts at the
// box carrying its own number and keeps following box contents until it finds
// its number, runs out of opens, or reads an out-of-range content. The run
// stops at the first failing prisoner.
module prisoners #(
  parameter int          NUM_PRISONERS = 8,
  parameter int          MAX_OPENS     = 4,
  parameter logic [31:0] GUARD_KEY     = 32'hC0DE_CAFE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        guard_key,
  input  logic [2:0]         state_reg,
  prisoners_if.master        box,
  output logic               busy,
  output logic               done,
  output logic               win,
  output logic [7:0]         fail_id,
  output logic               key_err
);

  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_CLEAR = 3'b010;
  localparam logic [2:0] CMD_ABORT = 3'b111;

  localparam logic [8:0] NUM_BOXES = 9'(NUM_PRISONERS);
  localparam logic [7:0] LAST_ID   = 8'(NUM_PRISONERS - 1);
  localparam logic [8:0] OPEN_MAX  = 9'(MAX_OPENS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EVAL,
    S_FINISH
  } state_t;

  state_t     state;
  logic [7:0] prisoner;
  logic [7:0] pointer;
  logic [8:0] opens;
  logic [7:0] captured;

  // Whole engine: command decode, box handshake and verdict bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      box.box_req  <= 1'b0;
      box.box_addr <= 8'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      win          <= 1'b0;
      fail_id      <= 8'hFF;
      key_err      <= 1'b0;
      prisoner     <= 8'd0;
      pointer      <= 8'd0;
      opens        <= 9'd0;
      captured     <= 8'd0;
    end else begin
      key_err <= 1'b0;
      if (busy && state_reg == CMD_ABORT) begin
        box.box_req <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        win         <= 1'b0;
        fail_id     <= prisoner;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (state_reg == CMD_START) begin
              if (guard_key == GUARD_KEY) begin
                busy     <= 1'b1;
                done     <= 1'b0;
                win      <= 1'b0;
                fail_id  <= 8'hFF;
                prisoner <= 8'd0;
                pointer  <= 8'd0;
                opens    <= 9'd0;
                state    <= S_REQ;
              end else begin
                key_err <= 1'b1;
              end
            end else if (state_reg == CMD_CLEAR) begin
              done    <= 1'b0;
              win     <= 1'b0;
              fail_id <= 8'hFF;
            end
          end
          S_REQ: begin
            box.box_req  <= 1'b1;
            box.box_addr <= pointer;
            state        <= S_WAIT;
          end
          S_WAIT: begin
            if (box.box_ack && box.box_req) begin
              captured    <= box.input_data;
              opens       <= opens + 9'd1;
              box.box_req <= 1'b0;
              state       <= S_EVAL;
            end
          end
          S_EVAL: begin
            if (captured == prisoner) begin
              if (prisoner == LAST_ID) begin
                win   <= 1'b1;
                state <= S_FINISH;
              end else begin
                prisoner <= prisoner + 8'd1;
                pointer  <= prisoner + 8'd1;
                opens    <= 9'd0;
                state    <= S_REQ;
              end
            end else if (({1'b0, captured} >= NUM_BOXES) || (opens == OPEN_MAX)) begin
              fail_id <= prisoner;
              win     <= 1'b0;
              state   <= S_FINISH;
            end else begin
              pointer <= captured;
              state   <= S_REQ;
            end
          end
          S_FINISH: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prisoners.sv
// Directed bench for the prisoners engine: a behavioural box store answers
// requests, stimulus pushes the expected request addresses and verdicts into
// queues, and a monitor pops and compares them as the engine presents them.
module tb_prisoners;

  localparam logic [31:0] KEY   = 32'hC0DE_CAFE;
  localparam logic [2:0]  NOP   = 3'b000;
  localparam logic [2:0]  START = 3'b001;
  localparam logic [2:0]  CLEAR = 3'b010;
  localparam logic [2:0]  ABORT = 3'b111;

  logic        clk;
  logic        rst_n;
  logic [31:0] guard_key;
  logic [2:0]  state_reg;
  logic        busy;
  logic        done;
  logic        win;
  logic [7:0]  fail_id;
  logic        key_err;

  prisoners_if bus ();

  prisoners #(
    .NUM_PRISONERS(8),
    .MAX_OPENS(4),
    .GUARD_KEY(KEY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .guard_key(guard_key),
    .state_reg(state_reg),
    .box(bus),
    .busy(busy),
    .done(done),
    .win(win),
    .fail_id(fail_id),
    .key_err(key_err)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:7];
  logic [7:0] stall_addr;
  logic       stall_en;
  logic       force_ack;

  logic [7:0] exp_addr_q[$];
  logic [8:0] exp_result_q[$];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run can never hang the simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Zero-wait box store: acks the cycle after it sees a request, unless the
  // requested box is currently stalled; force_ack injects a stray strobe.
  initial begin
    bus.box_ack    = 1'b0;
    bus.input_data = 8'd0;
    forever begin
      @(negedge clk);
      if (bus.box_req && !(stall_en && bus.box_addr == stall_addr)) begin
        bus.box_ack    = 1'b1;
        bus.input_data = mem[bus.box_addr[2:0]];
      end else begin
        bus.box_ack = force_ack;
      end
    end
  end

  // Scoreboard monitor: every new request and every verdict pops an expectation.
  initial begin
    logic       prev_req;
    logic       prev_done;
    logic [7:0] ea;
    logic [8:0] er;
    prev_req  = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.box_req && !prev_req) begin
        if (exp_addr_q.size() == 0) begin
          check_output("unexpected_request", {24'd0, bus.box_addr}, 32'hFFFF_FFFF);
        end else begin
          ea = exp_addr_q.pop_front();
          check_output("box_addr", {24'd0, bus.box_addr}, {24'd0, ea});
        end
      end
      if (done && !prev_done) begin
        if (exp_result_q.size() == 0) begin
          check_output("unexpected_done", {23'd0, win, fail_id}, 32'hFFFF_FFFF);
        end else begin
          er = exp_result_q.pop_front();
          check_output("verdict_win_failid", {23'd0, win, fail_id}, {23'd0, er});
        end
      end
      prev_req  = bus.box_req;
      prev_done = done;
    end
  end

  task automatic apply_stimulus(input logic [2:0] cmd, input logic [31:0] key);
    @(negedge clk);
    state_reg = cmd;
    guard_key = key;
    @(negedge clk);
    state_reg = NOP;
    guard_key = 32'd0;
  endtask

  task automatic wait_done(input string name, output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while (!done && n < 300) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      n++;
    end
    check_output({name, "_done_reached"}, {31'd0, done}, 32'd1);
    check_output({name, "_busy_cleared"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_req_addr(input string name, input logic [7:0] a);
    int n;
    n = 0;
    while (!(bus.box_req && bus.box_addr == a) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_req_seen"}, {31'd0, bus.box_req}, 32'd1);
  endtask

  // Directed test sequence.
  initial begin
    int bc;
    rst_n      = 1'b0;
    state_reg  = NOP;
    guard_key  = 32'd0;
    stall_en   = 1'b0;
    stall_addr = 8'd0;
    force_ack  = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    #23;
    check_output("reset_fail_id", {24'd0, fail_id}, 32'hFF);
    check_output("reset_flags", {28'd0, busy, done, win, key_err}, 32'd0);
    check_output("reset_box_req", {31'd0, bus.box_req}, 32'd0);
    rst_n = 1'b1;

    // 1: identity permutation, everyone wins.
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(8'(i));
    exp_result_q.push_back({1'b1, 8'hFF});
    apply_stimulus(START, KEY);
    check_output("t1_busy_after_start", {31'd0, busy}, 32'd1);
    wait_done("t1", bc);
    // 8 opens x 3 cycles, plus the FINISH cycle
    check_output("t1_busy_cycles", bc, 32'd25);

    // 3: wrong key pulses key_err once and leaves the verdict alone.
    apply_stimulus(START, 32'h0);
    check_output("t3_key_err_pulse", {31'd0, key_err}, 32'd1);
    check_output("t3_busy", {31'd0, busy}, 32'd0);
    check_output("t3_box_req", {31'd0, bus.box_req}, 32'd0);
    @(negedge clk);
    check_output("t3_key_err_drop", {31'd0, key_err}, 32'd0);
    check_output("t3_done_held", {31'd0, done}, 32'd1);
    check_output("t3_win_held", {31'd0, win}, 32'd1);

    // 2: single 8-cycle permutation, prisoner 0 runs out after 4 opens.
    for (int i = 0; i < 8; i++) mem[i] = 8'((i + 1) % 8);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(8'(i));
    exp_result_q.push_back({1'b0, 8'h00});
    apply_stimulus(START, KEY);
    check_output("t2_done_cleared", {31'd0, done}, 32'd0);
    wait_done("t2", bc);

    // 4: out-of-range content in box 0 fails prisoner 0 after one open.
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    mem[0] = 8'hF0;
    exp_addr_q.push_back(8'd0);
    exp_result_q.push_back({1'b0, 8'h00});
    apply_stimulus(START, KEY);
    wait_done("t4", bc);

    // 5: abort while prisoner 2 is waiting on box 2.
    mem[0] = 8'd0;
    stall_en   = 1'b1;
    stall_addr = 8'd2;
    for (int i = 0; i < 3; i++) exp_addr_q.push_back(8'(i));
    exp_result_q.push_back({1'b0, 8'h02});
    apply_stimulus(START, KEY);
    wait_req_addr("t5", 8'd2);
    apply_stimulus(ABORT, 32'd0);
    check_output("t5_box_req_dropped", {31'd0, bus.box_req}, 32'd0);
    check_output("t5_busy", {31'd0, busy}, 32'd0);
    check_output("t5_done", {31'd0, done}, 32'd1);
    check_output("t5_win", {31'd0, win}, 32'd0);
    check_output("t5_fail_id", {24'd0, fail_id}, 32'h02);
    apply_stimulus(CLEAR, 32'd0);
    check_output("t5_clear_done", {31'd0, done}, 32'd0);
    check_output("t5_clear_fail_id", {24'd0, fail_id}, 32'hFF);

    // 6: asynchronous reset in the middle of a wait; a late ack is ignored.
    stall_addr = 8'd1;
    exp_addr_q.push_back(8'd0);
    exp_addr_q.push_back(8'd1);
    apply_stimulus(START, KEY);
    wait_req_addr("t6", 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_async_box_req", {31'd0, bus.box_req}, 32'd0);
    check_output("t6_async_box_addr", {24'd0, bus.box_addr}, 32'd0);
    check_output("t6_async_busy", {31'd0, busy}, 32'd0);
    check_output("t6_async_fail_id", {24'd0, fail_id}, 32'hFF);
    #3;
    rst_n = 1'b1;
    stall_en  = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    check_output("t6_late_ack_box_req", {31'd0, bus.box_req}, 32'd0);
    check_output("t6_late_ack_flags", {29'd0, busy, done, win}, 32'd0);

    repeat (3) @(negedge clk);
    check_output("addr_queue_drained", exp_addr_q.size(), 32'd0);
    check_output("result_queue_drained", exp_result_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
